multi_channel_accumulator: RTL

//   Parametrised successor to the single 8-bit running-sum accumulator.

---
 rtl/multi_channel_accumulator.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multi_channel_accumulator.sv
// multi_channel_accumulator
//   CHANNELS independent running-sum accumulators with sticky per-channel
//   overflow/underflow flags, plus a dump FSM that streams every channel out
//   over a valid/ready handshake.
//   Optional feature macro: ACC_SATURATE_EN (clamp instead of wrap when
//   sat_mode=1). Without it the accumulators always wrap and sat_mode is unused.
module multi_channel_accumulator #(
  parameter  int CHANNELS = 4,
  parameter  int IN_W     = 8,
  parameter  int ACC_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [IN_W-1:0]     in_data,
  input  logic                in_sub,
  input  logic                sat_mode,
  input  logic                clr_all,
  input  logic                dump_req,
  output logic                dump_busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [ACC_W-1:0]    out_data,
  output logic [CHANNELS-1:0] ovf_flags
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Channel count and last index at the widths they are compared against
  localparam logic [CH_W:0]   CH_COUNT = (CH_W + 1)'(CHANNELS);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS - 1);
  localparam int              PAD_W    = ACC_W + 1 - IN_W;

  // ---------------------------------------------------------------------------
  // Accumulator datapath
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]    w_acc [CHANNELS];
  logic [CHANNELS-1:0] w_ovf;
  logic                w_in_range;
  logic                w_upd;
  logic [ACC_W-1:0]    w_sel_acc;
  logic [ACC_W:0]      w_operand;
  logic [ACC_W:0]      w_res;
  logic                w_carry;
  logic [ACC_W-1:0]    w_new;

  // Out-of-range channel indices are silently dropped; clear wins over update
  assign w_in_range = ({1'b0, in_ch} < CH_COUNT);
  assign w_upd      = in_valid & w_in_range & ~clr_all;

  // Select the addressed channel's current value (one shared adder for all)
  always_comb begin
    w_sel_acc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i)) begin
        w_sel_acc = w_acc[i];
      end
    end
  end

  // One extra bit captures carry on add and borrow on subtract
  assign w_operand = {{PAD_W{1'b0}}, in_data};
  assign w_res     = in_sub ? ({1'b0, w_sel_acc} - w_operand)
                            : ({1'b0, w_sel_acc} + w_operand);
  assign w_carry   = w_res[ACC_W];

`ifdef ACC_SATURATE_EN
  // Clamp to the rail the result ran past; the flag is still raised
  assign w_new = (sat_mode & w_carry) ? (in_sub ? {ACC_W{1'b0}} : {ACC_W{1'b1}})
                                      : w_res[ACC_W-1:0];
`else
  logic w_unused_sat;
  assign w_unused_sat = sat_mode;
  assign w_new        = w_res[ACC_W-1:0];
`endif

  // Per-channel storage: each channel owns its register and sticky flag
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             w_hit;

    assign w_hit = w_upd & (in_ch == CH_W'(gi));

    // Channel accumulator update with sticky overflow
    always_ff @(posedge clk) begin
      if (reset || clr_all) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (w_hit) begin
        r_acc <= w_new;
        r_ovf <= r_ovf | w_carry;
      end
    end

    assign w_acc[gi] = r_acc;
    assign w_ovf[gi] = r_ovf;
  end

  assign ovf_flags = w_ovf;

  // ---------------------------------------------------------------------------
  // Dump FSM
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic             w_load;
  logic [CH_W-1:0]  w_load_ch;
  logic [ACC_W-1:0] w_load_data;
  logic [CH_W-1:0]  r_out_ch;
  logic [ACC_W-1:0] r_out_data;

  // Next-state logic and beat-load decision
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_ch    = r_out_ch;
    case (r_state)
      ST_IDLE: begin
        // A clear in the same cycle suppresses the start so no stale
        // pre-clear value is ever emitted
        if (dump_req && !clr_all) begin
          w_state_next = ST_EMIT;
          w_load       = 1'b1;
          w_load_ch    = '0;
        end
      end
      ST_EMIT: begin
        if (clr_all) begin
          w_state_next = ST_IDLE;
        end else if (out_ready) begin
          if (r_out_ch == CH_LAST) begin
            w_state_next = ST_IDLE;
          end else begin
            w_load    = 1'b1;
            w_load_ch = r_out_ch + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Snapshot source: the accumulator value held before the loading edge
  always_comb begin
    w_load_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_load_ch == CH_W'(i)) begin
        w_load_data = w_acc[i];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Beat registers: only change when a new beat is loaded, so a stalled beat
  // stays frozen even if its source accumulator moves on
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_ch   <= '0;
      r_out_data <= '0;
    end else if (w_load) begin
      r_out_ch   <= w_load_ch;
      r_out_data <= w_load_data;
    end
  end

  assign out_valid = (r_state == ST_EMIT);
  assign dump_busy = (r_state == ST_EMIT);
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;

endmodule
